// File: rtl/conv_layer_ctrl_if.sv
// Control/status bundle between the conv layer sequencer and its host, datapath and pooling cache.
// master drives start/kernel_calc_fin/pool_ready; slave (the sequencer) drives everything else.
interface conv_layer_ctrl_if #(
    parameter int FIDX_W = 2,
    parameter int ROW_W  = 3
);
    logic              start;
    logic              kernel_calc_fin;
    logic              pool_ready;
    logic              conv_enable;
    logic              conv_clear;
    logic [FIDX_W-1:0] feature_idx;
    logic [ROW_W-1:0]  row_cnt;
    logic              out_valid;
    logic              busy;
    logic              done;
    logic              timeout_err;

    modport master (
        output start, kernel_calc_fin, pool_ready,
        input  conv_enable, conv_clear, feature_idx, row_cnt, out_valid, busy, done, timeout_err
    );

    modport slave (
        input  start, kernel_calc_fin, pool_ready,
        output conv_enable, conv_clear, feature_idx, row_cnt, out_valid, busy, done, timeout_err
    );
endinterface

// File: rtl/conv_layer_ctrl.sv
// Layer sequencer: walks NUM_KERNEL feature maps of ROWS_PER_KERNEL rows each, stalls on pooling backpressure, guards rows with a watchdog.
// All outputs registered; out_valid trails kernel_calc_fin by one cycle, done trails the DONE state by one cycle.
module conv_layer_ctrl #(
    parameter int NUM_KERNEL      = 4,
    parameter int ROWS_PER_KERNEL = 6,
    parameter int TIMEOUT         = 1023
) (
    input  logic             clk,
    input  logic             rst_n,
    conv_layer_ctrl_if.slave ctl
);
    localparam int FIDX_W = (NUM_KERNEL > 1) ? $clog2(NUM_KERNEL) : 1;
    localparam int ROW_W  = $clog2(ROWS_PER_KERNEL + 1);
    localparam int WD_W   = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_RUN, S_HOLD, S_NEXT, S_DONE} state_t;

    state_t            state, next_state;
    logic [FIDX_W-1:0] feature_idx;
    logic [ROW_W-1:0]  row_cnt;
    logic [WD_W-1:0]   watchdog;
    logic              conv_enable, conv_clear, out_valid, busy, done, timeout_err;
    logic              conv_enable_d, conv_clear_d, out_valid_d, busy_d, done_d;

    logic fin_run, last_row, last_kernel, wd_expire;
    assign fin_run     = (state == S_RUN) && ctl.kernel_calc_fin;
    assign last_row    = (row_cnt == ROW_W'(ROWS_PER_KERNEL - 1));
    assign last_kernel = (feature_idx == FIDX_W'(NUM_KERNEL - 1));
    // A row completing on the expiry cycle wins over the timeout.
    assign wd_expire   = (state == S_RUN) && !ctl.kernel_calc_fin && (watchdog == WD_W'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:  if (ctl.start) next_state = S_CLEAR;
            S_CLEAR: next_state = S_RUN;
            S_RUN: begin
                if (fin_run) begin
                    if (last_row)             next_state = S_NEXT;
                    else if (!ctl.pool_ready) next_state = S_HOLD;
                end else if (wd_expire) begin
                    next_state = S_IDLE;
                end
            end
            S_HOLD:  if (ctl.pool_ready) next_state = S_RUN;
            S_NEXT:  next_state = last_kernel ? S_DONE : S_CLEAR;
            S_DONE:  next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // done keys off the current state so it lands two cycles after the final row's out_valid.
    always_comb begin
        conv_enable_d = (next_state == S_RUN);
        conv_clear_d  = (next_state == S_CLEAR);
        busy_d        = (next_state != S_IDLE);
        out_valid_d   = fin_run;
        done_d        = (state == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            conv_enable <= 1'b0;
            conv_clear  <= 1'b0;
            out_valid   <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            timeout_err <= 1'b0;
            feature_idx <= '0;
            row_cnt     <= '0;
            watchdog    <= '0;
        end else begin
            conv_enable <= conv_enable_d;
            conv_clear  <= conv_clear_d;
            out_valid   <= out_valid_d;
            busy        <= busy_d;
            done        <= done_d;

            if ((state == S_IDLE) && ctl.start) begin
                feature_idx <= '0;
                row_cnt     <= '0;
                timeout_err <= 1'b0;
            end else if (fin_run) begin
                row_cnt <= row_cnt + ROW_W'(1);
            end else if ((state == S_NEXT) && !last_kernel) begin
                feature_idx <= feature_idx + FIDX_W'(1);
                row_cnt     <= '0;
            end

            if (wd_expire) timeout_err <= 1'b1;

            if ((next_state == S_RUN) && (state != S_RUN)) watchdog <= '0;
            else if (state == S_RUN)                       watchdog <= fin_run ? '0 : watchdog + WD_W'(1);
        end
    end

    assign ctl.conv_enable = conv_enable;
    assign ctl.conv_clear  = conv_clear;
    assign ctl.out_valid   = out_valid;
    assign ctl.busy        = busy;
    assign ctl.done        = done;
    assign ctl.timeout_err = timeout_err;
    assign ctl.feature_idx = feature_idx;
    assign ctl.row_cnt     = row_cnt;
endmodule

// File: tb/tb_conv_layer_ctrl.sv
// Directed bench for conv_layer_ctrl: full layer, pooling stall, last-row priority, mid-layer reset, watchdog, ignored requests.
module tb_conv_layer_ctrl;
    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;
    int   ov_cnt = 0, clr_cnt = 0, done_cnt = 0, overlap = 0;

    conv_layer_ctrl_if bus ();

    conv_layer_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ctl   (bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.out_valid) ov_cnt++;
        if (bus.conv_clear) clr_cnt++;
        if (bus.done) done_cnt++;
        if (bus.out_valid && bus.done) overlap++;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1);
    end

    // {conv_enable, conv_clear, out_valid, busy, done, timeout_err, feature_idx, row_cnt}
    function automatic logic [10:0] obs();
        return {bus.conv_enable, bus.conv_clear, bus.out_valid, bus.busy, bus.done,
                bus.timeout_err, bus.feature_idx, bus.row_cnt};
    endfunction

    function automatic logic [10:0] mk(input logic en, input logic clr, input logic ov, input logic bsy,
                                       input logic dn, input logic err, input int fi, input int rc);
        return {en, clr, ov, bsy, dn, err, 2'(fi), 3'(rc)};
    endfunction

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic run_rows(input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            repeat (gap) cyc();
            bus.kernel_calc_fin = 1'b1;
            cyc();
            bus.kernel_calc_fin = 1'b0;
        end
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        cyc();
        bus.start = 1'b0;
    endtask

    task automatic test_reset();
        logic [10:0] e;
        rst_n = 1'b0;
        bus.start = 1'b0;
        bus.kernel_calc_fin = 1'b0;
        bus.pool_ready = 1'b1;
        repeat (2) cyc();
        e = mk(0, 0, 0, 0, 0, 0, 0, 0);
        total++;
        if (obs() !== e) begin bad++; $display("FAIL reset_state: got %b want %b", obs(), e); end
        rst_n = 1'b1;
        repeat (5) cyc();
        total++;
        if (obs() !== e) begin bad++; $display("FAIL no_autostart: got %b want %b", obs(), e); end
    endtask

    task automatic test_full_layer();
        logic [10:0] e;
        int ov0, clr0, dn0;
        ov0 = ov_cnt; clr0 = clr_cnt; dn0 = done_cnt;
        pulse_start();
        e = mk(0, 1, 0, 1, 0, 0, 0, 0);
        total++;
        if (obs() !== e) begin bad++; $display("FAIL full_clear0: got %b want %b", obs(), e); end
        for (int k = 0; k < 4; k++) begin
            for (int r = 0; r < 6; r++) begin
                repeat (19) cyc();
                bus.kernel_calc_fin = 1'b1;
                cyc();
                bus.kernel_calc_fin = 1'b0;
                e = mk(r != 5, 0, 1, 1, 0, 0, k, r + 1);
                total++;
                if (obs() !== e) begin
                    bad++; $display("FAIL full_row k=%0d r=%0d: got %b want %b", k, r, obs(), e);
                end
            end
            cyc();
            e = (k < 3) ? mk(0, 1, 0, 1, 0, 0, k + 1, 0) : mk(0, 0, 0, 1, 0, 0, 3, 6);
            total++;
            if (obs() !== e) begin bad++; $display("FAIL full_next k=%0d: got %b want %b", k, obs(), e); end
        end
        cyc();
        e = mk(0, 0, 0, 0, 1, 0, 3, 6);
        total++;
        if (obs() !== e) begin bad++; $display("FAIL full_done: got %b want %b", obs(), e); end
        repeat (2) cyc();
        e = mk(0, 0, 0, 0, 0, 0, 3, 6);
        total++;
        if (obs() !== e) begin bad++; $display("FAIL full_hold_final: got %b want %b", obs(), e); end
        total++;
        if (ov_cnt - ov0 !== 24) begin bad++; $display("FAIL full_out_valid_count: got %0d want 24", ov_cnt - ov0); end
        total++;
        if (clr_cnt - clr0 !== 4) begin bad++; $display("FAIL full_clear_count: got %0d want 4", clr_cnt - clr0); end
        total++;
        if (done_cnt - dn0 !== 1) begin bad++; $display("FAIL full_done_count: got %0d want 1", done_cnt - dn0); end
    endtask

    task automatic test_hold();
        logic [10:0] e;
        pulse_start();
        run_rows(6, 3);
        run_rows(2, 3);
        repeat (3) cyc();
        bus.pool_ready = 1'b0;
        bus.kernel_calc_fin = 1'b1;
        cyc();
        bus.kernel_calc_fin = 1'b0;
        e = mk(0, 0, 1, 1, 0, 0, 1, 3);
        total++;
        if (obs() !== e) begin bad++; $display("FAIL hold_enter: got %b want %b", obs(), e); end
        repeat (25) cyc();
        bus.kernel_calc_fin = 1'b1;
        cyc();
        bus.kernel_calc_fin = 1'b0;
        e = mk(0, 0, 0, 1, 0, 0, 1, 3);
        total++;
        if (obs() !== e) begin bad++; $display("FAIL hold_fin_ignored: got %b want %b", obs(), e); end
        repeat (24) cyc();
        bus.pool_ready = 1'b1;
        cyc();
        e = mk(1, 0, 0, 1, 0, 0, 1, 3);
        total++;
        if (obs() !== e) begin bad++; $display("FAIL hold_resume: got %b want %b", obs(), e); end
    endtask

    task automatic test_last_row_priority();
        logic [10:0] e;
        run_rows(2, 3);
        repeat (3) cyc();
        bus.pool_ready = 1'b0;
        bus.kernel_calc_fin = 1'b1;
        cyc();
        bus.kernel_calc_fin = 1'b0;
        e = mk(0, 0, 1, 1, 0, 0, 1, 6);
        total++;
        if (obs() !== e) begin bad++; $display("FAIL last_row_next: got %b want %b", obs(), e); end
        cyc();
        e = mk(0, 1, 0, 1, 0, 0, 2, 0);
        total++;
        if (obs() !== e) begin bad++; $display("FAIL last_row_clear: got %b want %b", obs(), e); end
        bus.pool_ready = 1'b1;
        cyc();
        e = mk(1, 0, 0, 1, 0, 0, 2, 0);
        total++;
        if (obs() !== e) begin bad++; $display("FAIL last_row_run: got %b want %b", obs(), e); end
    endtask

    task automatic test_reset_mid();
        logic [10:0] e;
        run_rows(4, 3);
        e = mk(1, 0, 1, 1, 0, 0, 2, 4);
        total++;
        if (obs() !== e) begin bad++; $display("FAIL mid_row4: got %b want %b", obs(), e); end
        repeat (2) cyc();
        rst_n = 1'b0;
        #1;
        e = mk(0, 0, 0, 0, 0, 0, 0, 0);
        total++;
        if (obs() !== e) begin bad++; $display("FAIL mid_reset_async: got %b want %b", obs(), e); end
        cyc();
        rst_n = 1'b1;
        repeat (3) cyc();
        total++;
        if (obs() !== e) begin bad++; $display("FAIL mid_reset_idle: got %b want %b", obs(), e); end
        pulse_start();
        e = mk(0, 1, 0, 1, 0, 0, 0, 0);
        total++;
        if (obs() !== e) begin bad++; $display("FAIL mid_restart: got %b want %b", obs(), e); end
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        cyc();
    endtask

    task automatic test_timeout_and_ignore();
        logic [10:0] e;
        int n, dn0, clr0;
        dn0 = done_cnt;
        n = 0;
        bus.start = 1'b1;
        while (n < 1100) begin
            cyc();
            n++;
            bus.start = 1'b0;
            if (bus.timeout_err) break;
        end
        total++;
        if (n !== 1025) begin bad++; $display("FAIL timeout_latency: got %0d cycles want 1025", n); end
        e = mk(0, 0, 0, 0, 0, 1, 0, 0);
        total++;
        if (obs() !== e) begin bad++; $display("FAIL timeout_state: got %b want %b", obs(), e); end
        bus.kernel_calc_fin = 1'b1;
        cyc();
        bus.kernel_calc_fin = 1'b0;
        cyc();
        total++;
        if (obs() !== e) begin bad++; $display("FAIL idle_fin_ignored: got %b want %b", obs(), e); end
        total++;
        if (done_cnt - dn0 !== 0) begin bad++; $display("FAIL timeout_no_done: got %0d want 0", done_cnt - dn0); end
        clr0 = clr_cnt;
        pulse_start();
        e = mk(0, 1, 0, 1, 0, 0, 0, 0);
        total++;
        if (obs() !== e) begin bad++; $display("FAIL restart_clears_err: got %b want %b", obs(), e); end
        cyc();
        pulse_start();
        e = mk(1, 0, 0, 1, 0, 0, 0, 0);
        total++;
        if (obs() !== e) begin bad++; $display("FAIL busy_start_ignored: got %b want %b", obs(), e); end
        repeat (2) cyc();
        total++;
        if (clr_cnt - clr0 !== 1) begin bad++; $display("FAIL busy_start_clears: got %0d want 1", clr_cnt - clr0); end
    endtask

    initial begin
        test_reset();
        test_full_layer();
        test_hold();
        test_last_row_priority();
        test_reset_mid();
        test_timeout_and_ignore();
        total++;
        if (overlap !== 0) begin bad++; $display("FAIL valid_done_overlap: got %0d want 0", overlap); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
